// File: rtl/fec_enc_arb.sv
// fec_enc_arb: round-robin packet arbiter muxing two fabric sinks onto one FEC encoder source
// Each grant holds until its owner drops cyc; an inter-frame gap of g_ifg idle cycles follows.
module fec_enc_arb #(
  parameter int g_ifg       = 2,
  parameter int g_cnt_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   snk0_cyc_i,
  input  logic                   snk0_stb_i,
  input  logic                   snk0_we_i,
  input  logic [1:0]             snk0_sel_i,
  input  logic [1:0]             snk0_adr_i,
  input  logic [15:0]            snk0_dat_i,
  output logic                   snk0_stall_o,
  output logic                   snk0_ack_o,
  input  logic                   snk1_cyc_i,
  input  logic                   snk1_stb_i,
  input  logic                   snk1_we_i,
  input  logic [1:0]             snk1_sel_i,
  input  logic [1:0]             snk1_adr_i,
  input  logic [15:0]            snk1_dat_i,
  output logic                   snk1_stall_o,
  output logic                   snk1_ack_o,
  output logic                   src_cyc_o,
  output logic                   src_stb_o,
  output logic                   src_we_o,
  output logic [1:0]             src_sel_o,
  output logic [1:0]             src_adr_o,
  output logic [15:0]            src_dat_o,
  input  logic                   src_stall_i,
  input  logic                   src_ack_i,
  output logic [g_cnt_width-1:0] pkt_cnt0_o,
  output logic [g_cnt_width-1:0] pkt_cnt1_o,
  output logic [1:0]             grant_o,
  output logic                   err_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;
  localparam logic [3:0] c_gap_last = 4'(g_ifg - 1);
  localparam state_t     c_after    = (g_ifg == 0) ? IDLE : GAP;
  state_t                 r_state, w_next;
  logic [3:0]             r_gap;
  logic                   r_last, r_orphan, r_err;
  logic [g_cnt_width-1:0] r_cnt0, r_cnt1;
  logic                   w_own0, w_own1, w_eop0, w_eop1, w_orphan;
  assign w_eop0   = (r_state == GNT0) && !snk0_cyc_i;
  assign w_eop1   = (r_state == GNT1) && !snk1_cyc_i;
  assign w_orphan = src_ack_i && (r_state == IDLE || r_state == GAP);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_gap    <= '0;
      r_last   <= 1'b1;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
      r_orphan <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_gap    <= (r_state == GAP) ? r_gap + 4'd1 : 4'd0;
      r_orphan <= w_orphan;
      r_err    <= w_orphan && !r_orphan;
      if (w_eop0) begin
        r_cnt0 <= r_cnt0 + 1'b1;
        r_last <= 1'b0;
      end
      if (w_eop1) begin
        r_cnt1 <= r_cnt1 + 1'b1;
        r_last <= 1'b1;
      end
    end
  end
  // On a tie, port 0 wins only if port 1 owned the previous packet.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en_i && snk0_cyc_i && (!snk1_cyc_i || r_last)) w_next = GNT0;
               else if (en_i && snk1_cyc_i) w_next = GNT1;
      GNT0:    if (!snk0_cyc_i) w_next = c_after;
      GNT1:    if (!snk1_cyc_i) w_next = c_after;
      default: if (r_gap == c_gap_last) w_next = IDLE;
    endcase
  end
  // Ownership is masked by rst_i so the source fabric is quiet throughout reset.
  always_comb begin
    w_own0       = (r_state == GNT0) && !rst_i;
    w_own1       = (r_state == GNT1) && !rst_i;
    src_cyc_o    = w_own0 ? snk0_cyc_i : w_own1 ? snk1_cyc_i : 1'b0;
    src_stb_o    = w_own0 ? snk0_stb_i : w_own1 ? snk1_stb_i : 1'b0;
    src_we_o     = w_own0 ? snk0_we_i  : w_own1 ? snk1_we_i  : 1'b0;
    src_sel_o    = w_own0 ? snk0_sel_i : w_own1 ? snk1_sel_i : 2'b00;
    src_adr_o    = w_own0 ? snk0_adr_i : w_own1 ? snk1_adr_i : 2'b00;
    src_dat_o    = w_own0 ? snk0_dat_i : w_own1 ? snk1_dat_i : 16'h0000;
    snk0_stall_o = w_own0 ? src_stall_i : 1'b1;
    snk1_stall_o = w_own1 ? src_stall_i : 1'b1;
    snk0_ack_o   = w_own0 && src_ack_i;
    snk1_ack_o   = w_own1 && src_ack_i;
    grant_o      = {w_own1, w_own0};
    pkt_cnt0_o   = r_cnt0;
    pkt_cnt1_o   = r_cnt1;
    err_o        = r_err;
  end
endmodule

// File: tb/tb_fec_enc_arb.sv
// tb_fec_enc_arb: directed scenario bench for fec_enc_arb (g_ifg=2, 4-bit packet counters)
module tb_fec_enc_arb;
  localparam int IFG = 2;
  localparam int CW  = 4;
  logic          clk = 1'b0;
  logic          rst, en, src_stall, src_ack;
  logic [1:0]    snk_cyc, snk_stb, snk_we, snk_stall, snk_ack;
  logic [1:0]    snk_sel [2];
  logic [1:0]    snk_adr [2];
  logic [15:0]   snk_dat [2];
  logic          src_cyc_o, src_stb_o, src_we_o, err_o;
  logic [1:0]    src_sel_o, src_adr_o, grant_o;
  logic [15:0]   src_dat_o;
  logic [CW-1:0] pkt_cnt0_o, pkt_cnt1_o;
  logic [CW-1:0] exp_cnt [2];
  logic          exp_last;
  int            vecs = 0;
  int            errs = 0;

  always #5 clk = ~clk;

  fec_enc_arb #(.g_ifg(IFG), .g_cnt_width(CW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .snk0_cyc_i(snk_cyc[0]), .snk0_stb_i(snk_stb[0]), .snk0_we_i(snk_we[0]),
    .snk0_sel_i(snk_sel[0]), .snk0_adr_i(snk_adr[0]), .snk0_dat_i(snk_dat[0]),
    .snk0_stall_o(snk_stall[0]), .snk0_ack_o(snk_ack[0]),
    .snk1_cyc_i(snk_cyc[1]), .snk1_stb_i(snk_stb[1]), .snk1_we_i(snk_we[1]),
    .snk1_sel_i(snk_sel[1]), .snk1_adr_i(snk_adr[1]), .snk1_dat_i(snk_dat[1]),
    .snk1_stall_o(snk_stall[1]), .snk1_ack_o(snk_ack[1]),
    .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
    .src_sel_o(src_sel_o), .src_adr_o(src_adr_o), .src_dat_o(src_dat_o),
    .src_stall_i(src_stall), .src_ack_i(src_ack),
    .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o),
    .grant_o(grant_o), .err_o(err_o)
  );

  function automatic logic [15:0] wd(input int p, input int i);
    return 16'(p * 4096 + i * 7 + 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b1; src_stall = 1'b0; src_ack = 1'b0;
    snk_cyc = 2'b00; snk_stb = 2'b00; snk_we = 2'b00;
    for (int k = 0; k < 2; k++) begin
      snk_sel[k] = 2'b00; snk_adr[k] = 2'b00; snk_dat[k] = 16'h0000;
    end
    tick;
    rst = 1'b0;
    exp_cnt[0] = '0; exp_cnt[1] = '0; exp_last = 1'b1;
  endtask

  task automatic wait_grant(input int p);
    logic [1:0] g;
    int n;
    g = 2'b01 << p;
    n = 0;
    while (grant_o !== g && n < 20) begin
      tick;
      n++;
    end
    vecs++;
    if (grant_o !== g) begin
      errs++;
      $display("FAIL wait_grant%0d: grant_o=%b required %b", p, grant_o, g);
    end
  endtask

  // Moves n words through an already granted port p, then ends the packet.
  task automatic xfer(input int p, input int n, input bit rnd);
    logic [1:0]  g;
    logic [28:0] act, req;
    int i, guard;
    g = 2'b01 << p;
    i = 0; guard = 0;
    snk_stb[p] = 1'b1; snk_we[p] = 1'b1; snk_sel[p] = 2'b11;
    while (i < n && guard < 4000) begin
      snk_dat[p] = wd(p, i);
      snk_adr[p] = 2'(i);
      src_stall  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      src_ack    = ~src_stall;
      #1;
      act = {src_cyc_o, src_stb_o, src_we_o, src_sel_o, src_adr_o, src_dat_o,
             snk_stall[p], snk_ack[p], snk_stall[1-p], snk_ack[1-p], grant_o};
      req = {3'b111, 2'b11, 2'(i), wd(p, i), src_stall, ~src_stall, 1'b1, 1'b0, g};
      vecs++;
      if (act !== req) begin
        errs++;
        $display("FAIL word p%0d[%0d]: got %h required %h", p, i, act, req);
      end
      if (!src_stall) i++;
      tick;
      guard++;
    end
    vecs++;
    if (i != n) begin
      errs++;
      $display("FAIL xfer_budget p%0d: moved %0d words required %0d", p, i, n);
    end
    snk_cyc[p] = 1'b0; snk_stb[p] = 1'b0; src_stall = 1'b0; src_ack = 1'b0;
    #1;
    vecs++;
    if ({src_cyc_o, grant_o} !== {1'b0, g}) begin
      errs++;
      $display("FAIL eop_cycle p%0d: cyc,grant=%b required %b", p, {src_cyc_o, grant_o}, {1'b0, g});
    end
    tick;
    exp_cnt[p] = exp_cnt[p] + 1'b1;
    exp_last = 1'(p);
    vecs++;
    if ({grant_o, pkt_cnt1_o, pkt_cnt0_o} !== {2'b00, exp_cnt[1], exp_cnt[0]}) begin
      errs++;
      $display("FAIL after_eop p%0d: grant,cnt1,cnt0=%h required %h", p,
               {grant_o, pkt_cnt1_o, pkt_cnt0_o}, {2'b00, exp_cnt[1], exp_cnt[0]});
    end
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    vecs++;
    if ({grant_o, src_cyc_o, src_stb_o, src_dat_o, err_o, pkt_cnt0_o, pkt_cnt1_o, snk_stall, snk_ack}
        !== {2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 4'd0, 2'b11, 2'b00}) begin
      errs++;
      $display("FAIL reset: grant=%b cyc=%b dat=%h err=%b cnt0=%0d cnt1=%0d stall=%b ack=%b", grant_o,
               src_cyc_o, src_dat_o, err_o, pkt_cnt0_o, pkt_cnt1_o, snk_stall, snk_ack);
    end
  endtask

  task automatic test_single_port;
    snk_cyc[0] = 1'b1;
    wait_grant(0);
    xfer(0, 256, 1'b1);
    vecs++;
    if ({pkt_cnt0_o, pkt_cnt1_o, grant_o} !== {4'd1, 4'd0, 2'b00}) begin
      errs++;
      $display("FAIL single_port: cnt0=%0d cnt1=%0d grant=%b required 1 0 00", pkt_cnt0_o, pkt_cnt1_o, grant_o);
    end
  endtask

  task automatic test_round_robin;
    int p, n;
    do_reset;
    snk_cyc = 2'b11;
    for (int k = 0; k < 8; k++) begin
      p = exp_last ? 0 : 1;
      vecs++;
      if (p != k % 2) begin
        errs++;
        $display("FAIL rr_order pkt%0d: port %0d required %0d", k, p, k % 2);
      end
      wait_grant(p);
      xfer(p, 3, 1'b0);
      if (k < 7) begin
        snk_cyc[p] = 1'b1;
        n = 0;
        while (grant_o === 2'b00 && n < 20) begin
          vecs++;
          if (src_cyc_o !== 1'b0) begin
            errs++;
            $display("FAIL rr_gap_cyc pkt%0d: src_cyc_o=%b required 0", k, src_cyc_o);
          end
          n++;
          tick;
        end
        vecs++;
        if (n != IFG + 1) begin
          errs++;
          $display("FAIL rr_gap pkt%0d: %0d idle cycles required %0d", k, n, IFG + 1);
        end
      end else snk_cyc = 2'b00;
    end
    vecs++;
    if ({pkt_cnt0_o, pkt_cnt1_o} !== {4'd4, 4'd4}) begin
      errs++;
      $display("FAIL rr_counts: cnt0=%0d cnt1=%0d required 4 4", pkt_cnt0_o, pkt_cnt1_o);
    end
  endtask

  task automatic test_en_block;
    snk_cyc[1] = 1'b1;
    wait_grant(1);
    en = 1'b0;
    snk_cyc[0] = 1'b1;
    xfer(1, 4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if ({grant_o, snk_stall[0]} !== 3'b001) begin
        errs++;
        $display("FAIL en_block cyc%0d: grant=%b stall0=%b required 00 1", k, grant_o, snk_stall[0]);
      end
      tick;
    end
    en = 1'b1;
    tick;
    vecs++;
    if (grant_o !== 2'b01) begin
      errs++;
      $display("FAIL en_release: grant=%b required 01", grant_o);
    end
    xfer(0, 2, 1'b0);
  endtask

  task automatic test_err;
    int hi;
    hi = 0;
    src_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) src_ack = 1'b0;
      #1;
      hi += int'(err_o);
      vecs++;
      if (snk_ack !== 2'b00) begin
        errs++;
        $display("FAIL err_ack_leak cyc%0d: snk_ack=%b required 00", k, snk_ack);
      end
      tick;
    end
    vecs++;
    if (hi != 1) begin
      errs++;
      $display("FAIL err_pulse: err_o high %0d cycles required 1", hi);
    end
  endtask

  task automatic test_reset_mid;
    snk_cyc[1] = 1'b1;
    wait_grant(1);
    snk_stb[1] = 1'b1;
    snk_dat[1] = 16'hbeef;
    tick;
    rst = 1'b1;
    #1;
    vecs++;
    if ({src_cyc_o, grant_o} !== 3'b000) begin
      errs++;
      $display("FAIL reset_hold: cyc,grant=%b required 000", {src_cyc_o, grant_o});
    end
    tick;
    rst = 1'b0;
    exp_cnt[0] = '0; exp_cnt[1] = '0; exp_last = 1'b1;
    vecs++;
    if ({src_cyc_o, grant_o, pkt_cnt0_o, pkt_cnt1_o} !== {1'b0, 2'b00, 4'd0, 4'd0}) begin
      errs++;
      $display("FAIL reset_mid: cyc=%b grant=%b cnt0=%0d cnt1=%0d required 0 00 0 0",
               src_cyc_o, grant_o, pkt_cnt0_o, pkt_cnt1_o);
    end
    snk_cyc[0] = 1'b1;
    tick;
    vecs++;
    if (grant_o !== 2'b01) begin
      errs++;
      $display("FAIL reset_tie: grant=%b required 01", grant_o);
    end
    snk_cyc[1] = 1'b0; snk_stb[1] = 1'b0;
    xfer(0, 2, 1'b0);
  endtask

  task automatic test_wrap;
    do_reset;
    for (int k = 0; k < 17; k++) begin
      snk_cyc[0] = 1'b1;
      wait_grant(0);
      xfer(0, 1, 1'b0);
    end
    vecs++;
    if (pkt_cnt0_o !== 4'd1) begin
      errs++;
      $display("FAIL wrap: cnt0=%0d required 1", pkt_cnt0_o);
    end
  endtask

  initial begin
    test_reset;
    test_single_port;
    test_round_robin;
    test_en_block;
    test_err;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fec_enc_arb.md
FEC_ENC_ARB -- requirements
Module: fec_enc_arb

Interface
REQ-001 The block SHALL have generic g_ifg, default 2: idle cycles forced on the source between packets (0..15).
REQ-002 The block SHALL have generic g_cnt_width, default 16: width of the per-port packet counters.
REQ-003 The block SHALL have port clk_i, in, 1: single clock for all logic.
REQ-004 The block SHALL have port rst_i, in, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port en_i, in, 1: grant enable; low blocks new grants only.
REQ-006 The block SHALL have ports snk0_cyc_i, snk0_stb_i and snk0_we_i, in, 1 each: port-0 fabric controls.
REQ-007 The block SHALL have ports snk0_sel_i (in, 2), snk0_adr_i (in, 2) and snk0_dat_i (in, 16): port-0 fabric qualifiers and data.
REQ-008 The block SHALL have ports snk0_stall_o and snk0_ack_o, out, 1 each: port-0 flow control.
REQ-009 The block SHALL have the snk1_* port set, identical to REQ-006..008: port-1 fabric.
REQ-010 The block SHALL have ports src_cyc_o, src_stb_o and src_we_o (out, 1), src_sel_o (out, 2), src_adr_o (out, 2) and src_dat_o (out, 16): fabric toward the FEC encoder sink.
REQ-011 The block SHALL have ports src_stall_i and src_ack_i, in, 1 each: encoder flow control.
REQ-012 The block SHALL have ports pkt_cnt0_o and pkt_cnt1_o, out, g_cnt_width: completed packets per port.
REQ-013 The block SHALL have port grant_o, out, 2: one-hot current owner, 00 when none.
REQ-014 The block SHALL have port err_o, out, 1: one-cycle pulse on a src_ack_i arriving with no owner.

Function
REQ-015 The FSM SHALL use states IDLE, GNT0, GNT1 and GAP; all transitions SHALL be registered.
REQ-016 In IDLE with en_i=1 and exactly one snkN_cyc_i=1, the FSM SHALL go to GNTN on the next cycle.
REQ-017 When both snkN_cyc_i are high in IDLE, the grant SHALL go to the port not granted last (round-robin); after reset the last-granted pointer is 1, so port 0 wins the first tie.
REQ-018 In IDLE with en_i=0, the FSM SHALL stay in IDLE regardless of requests.
REQ-019 In GNTN, src_cyc/stb/we/sel/adr/dat_o SHALL be combinational copies of snkN_*_i; snkN_stall_o SHALL equal src_stall_i and snkN_ack_o SHALL equal src_ack_i (zero added latency).
REQ-020 A port that is not granted, in any state, SHALL see stall_o=1 and ack_o=0; its cyc SHALL be held pending without loss.
REQ-021 In IDLE and GAP: src_cyc_o=0, src_stb_o=0, src_we_o=0, src_sel_o=0, src_adr_o=0, src_dat_o=0.
REQ-022 In GNTN, a cycle with snkN_cyc_i=0 SHALL end the packet: pkt_cntN increments by 1 (modulo 2^g_cnt_width, max wraps to 0), the last-granted pointer is set to N, and the FSM goes to GAP (or to IDLE if g_ifg=0).
REQ-023 GAP SHALL last exactly g_ifg cycles, then go to IDLE; arbitration resumes in IDLE, so the next grant occurs g_ifg+1 cycles after the end-of-packet cycle.
REQ-024 en_i falling during GNTN SHALL NOT truncate the packet; it only blocks the next grant.
REQ-025 src_ack_i=1 in IDLE or GAP SHALL be discarded and SHALL pulse err_o for one cycle; otherwise err_o=0.
REQ-026 grant_o SHALL be 01 in GNT0, 10 in GNT1, and 00 otherwise.
REQ-027 A port that raises cyc in the same cycle the other port's packet ends SHALL be granted from the IDLE following GAP, per REQ-017.

Reset
REQ-028 While rst_i=1 at a clk_i edge: FSM to IDLE, gap counter to 0, last-granted pointer to 1, pkt_cnt0_o and pkt_cnt1_o to 0, err_o to 0.
REQ-029 Outputs SHALL take IDLE values per REQ-020/021 while in reset; an in-flight packet SHALL be abandoned, with src_cyc_o low the cycle after rst_i is sampled.

Verification
REQ-030 Port 0 only, 512-byte packet (256 words), src_stall_i random -> all 256 words appear on src_* in order, pkt_cnt0_o=1, pkt_cnt1_o=0, grant_o back to 00.
REQ-031 Both ports hold cyc continuously, 4 packets each, g_ifg=2 -> grant order 0,1,0,1,...; a gap of exactly 3 src_cyc_o-low cycles between packets; both counters=4.
REQ-032 en_i=0 mid-packet on port 1 -> the packet completes and pkt_cnt1_o increments; port 0's pending cyc is not granted until en_i=1.
REQ-033 src_ack_i forced high during GAP -> err_o high for exactly one cycle; no ack reaches either sink.
REQ-034 g_cnt_width=4, 17 packets on port 0 -> pkt_cnt0_o reads 1.
REQ-035 rst_i asserted for one cycle mid-packet -> src_cyc_o=0 the next cycle, both counters 0, and the next tie is granted to port 0.
